result_unloader: RTL and testbench
==================================

Name: result_unloader

Overview:
- Drain side of the matrix-multiply datapath; the counterpart of the memory-bank loader that writes W/X one element per cycle by row/col address.
- Snapshots the N x N result matrix from the matrix multiplier on a load pulse.
- Streams the matrix out one element per transfer, in row-major order, with its row/col tag, under a valid/ready handshake.
- Sits between matrix_multiplier and the host/output port.

Parameters:
- N, 3, matrix dimension (rows = cols = N).
- DATA_W, 4, operand element width (matches data_in).
- ACC_W, 10, result element width; must be >= 2*DATA_W + ceil(log2(N)).
- IDX_W, 2, row/col index width; must be >= ceil(log2(N)).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- res_load  input  1  one-cycle pulse; result matrix on res_flat is valid this cycle.
- res_flat  input  N*N*ACC_W  result matrix, element (r,c) at bits [(r*N+c)*ACC_W +: ACC_W].
- out_data  output  ACC_W  current element.
- out_row  output  IDX_W  row index of out_data.
- out_col  output  IDX_W  column index of out_data.
- out_valid  output  1  out_data/out_row/out_col valid.
- out_ready  input  1  consumer accepts when out_valid & out_ready.
- out_last  output  1  high with element (N-1,N-1).
- busy  output  1  snapshot held / streaming in progress.
- overrun  output  1  sticky: a res_load was dropped.
- ovr_clr  input  1  synchronous clear of overrun.

Behaviour:
- Reset (async, rst=1): state IDLE; out_data=0, out_row=0, out_col=0, out_valid=0, out_last=0, busy=0, overrun=0; snapshot registers cleared. Reset mid-stream aborts with no partial output afterwards.
- FSM states are IDLE and SEND.
- IDLE:
  - res_load=1 captures all of res_flat into the snapshot registers.
  - Sets row=col=0 and moves to SEND.
  - out_valid and busy go high the next cycle (1-cycle latency), showing element (0,0).
- SEND:
  - out_valid=1 and busy=1.
  - Outputs are registered and held stable while out_valid & !out_ready. Stalls of any length are legal.
- Transfer (out_valid & out_ready):
  - Advance col. At col=N-1, wrap col to 0 and increment row.
  - Row and col never reach N.
  - Next element appears the following cycle, so throughput is one element per cycle with out_ready held high.
- out_last = (row==N-1) & (col==N-1) & out_valid.
- Transfer with out_last:
  - Without a simultaneous res_load: return to IDLE; out_valid, busy and out_last drop the next cycle.
  - With a simultaneous res_load: capture the new matrix, reset indices to (0,0), stay in SEND, no gap cycle, no overrun.
- res_load in SEND other than on the final transfer: ignored, snapshot unchanged, overrun set to 1.
- overrun:
  - ovr_clr=1 clears it.
  - A same-cycle dropped res_load takes precedence, so overrun stays 1.
- out_data is the snapshot element at index row*N+col, copied without arithmetic: no truncation or sign handling (unsigned).
- Changes to res_flat after capture have no effect on the stream.

Decomposition:
- Shared package mm_pkg holds:
  - constants N, DATA_W, ACC_W, IDX_W, shared with mem_bank and matrix_multiplier;
  - the state enum (ST_IDLE, ST_SEND);
  - an element-index helper function (r*N+c).
- One natural sub-module: rc_counter, a row/col wrap counter with clear, enable and a last flag.
  - Same counter the loader side can reuse for address generation.

Test Plan:
- Basic stream: res_load with element(r,c)=10*r+c, out_ready=1 → 9 transfers on consecutive cycles starting 1 cycle after the load; data 0,1,2,10,11,12,20,21,22; (row,col) (0,0)…(2,2); out_last only on 22; busy drops after.
- Backpressure: out_ready toggling 1,0,0,1… with max values 1023 → every element appears exactly once in order, outputs stable during stalls, no value truncated.
- Dropped load: second res_load during element (1,1) → stream still carries the first matrix; overrun=1; ovr_clr pulse → overrun=0.
- Back-to-back: second res_load coincident with the (2,2) transfer → next cycle shows (0,0) of the new matrix, out_valid stays high, overrun stays 0.
- Async reset: rst asserted mid-stream at (1,0) → outputs zero immediately without a clock edge; after release out_valid stays 0 until the next res_load.
- Snapshot isolation: change res_flat every cycle after the load → output equals the captured matrix.

Source files
------------

// File: rtl/mm_pkg.sv
// Shared constants, FSM state type and element-index helper for the
// matrix-multiply datapath (loader, multiplier, unloader).
package mm_pkg;

    localparam int N      = 3;
    localparam int DATA_W = 4;
    localparam int ACC_W  = 10;
    localparam int IDX_W  = 2;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_t;

    // Row-major flat index of element (r,c) in an n-wide matrix.
    function automatic int elem_idx(input int r, input int c, input int n);
        return r * n + c;
    endfunction

endpackage

// File: rtl/rc_counter.sv
// Row/column wrap counter: col advances on en, wraps into row; clr returns to (0,0).
// row_next/col_next expose the upcoming position so callers can prefetch data.
module rc_counter #(
    parameter int ROWS = 3,
    parameter int COLS = 3,
    parameter int W    = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] row,
    output logic [W-1:0] col,
    output logic [W-1:0] row_next,
    output logic [W-1:0] col_next,
    output logic         last
);

    logic [W-1:0] row_reg;
    logic [W-1:0] col_reg;

    always_comb begin
        row_next = row_reg;
        col_next = col_reg;
        if (clr) begin
            row_next = '0;
            col_next = '0;
        end else if (en) begin
            if (col_reg == W'(COLS - 1)) begin
                col_next = '0;
                row_next = (row_reg == W'(ROWS - 1)) ? '0 : row_reg + 1'b1;
            end else begin
                col_next = col_reg + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row_reg <= '0;
            col_reg <= '0;
        end else begin
            row_reg <= row_next;
            col_reg <= col_next;
        end
    end

    assign row  = row_reg;
    assign col  = col_reg;
    assign last = (row_reg == W'(ROWS - 1)) && (col_reg == W'(COLS - 1));

endmodule

// File: rtl/result_unloader.sv
// Snapshots the N x N result matrix on res_load and streams it out row-major,
// one tagged element per valid/ready transfer.
module result_unloader #(
    parameter int N      = mm_pkg::N,
    parameter int DATA_W = mm_pkg::DATA_W,
    parameter int ACC_W  = mm_pkg::ACC_W,
    parameter int IDX_W  = mm_pkg::IDX_W
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 res_load,
    input  logic [N*N*ACC_W-1:0] res_flat,
    output logic [ACC_W-1:0]     out_data,
    output logic [IDX_W-1:0]     out_row,
    output logic [IDX_W-1:0]     out_col,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 out_last,
    output logic                 busy,
    output logic                 overrun,
    input  logic                 ovr_clr
);
    import mm_pkg::*;

    localparam int NN    = N * N;
    localparam int SEL_W = (NN > 1) ? $clog2(NN) : 1;

    if (ACC_W < 2 * DATA_W + $clog2(N)) begin : g_bad_acc_w
        $error("ACC_W too narrow for DATA_W products summed over N terms");
    end
    if (IDX_W < $clog2(N)) begin : g_bad_idx_w
        $error("IDX_W too narrow to index N rows/cols");
    end

    state_t             state_reg, state_next;
    logic [ACC_W-1:0]   snap_reg [NN];
    logic [ACC_W-1:0]   out_data_reg, out_data_next;
    logic               overrun_reg, overrun_next;

    logic [IDX_W-1:0]   row, col, row_next, col_next;
    logic               at_last;
    logic               xfer, final_xfer, capture, drop;
    logic [SEL_W-1:0]   next_sel;

    assign xfer       = (state_reg == ST_SEND) && out_ready;
    assign final_xfer = xfer && at_last;
    // A load is accepted when idle or exactly on the closing transfer; anything
    // else while sending would corrupt the stream, so it is dropped and flagged.
    assign capture    = res_load && ((state_reg == ST_IDLE) || final_xfer);
    assign drop       = res_load && (state_reg == ST_SEND) && !final_xfer;

    rc_counter #(
        .ROWS (N),
        .COLS (N),
        .W    (IDX_W)
    ) u_rc (
        .clk      (clk),
        .rst      (rst),
        .clr      (capture || final_xfer),
        .en       (xfer),
        .row      (row),
        .col      (col),
        .row_next (row_next),
        .col_next (col_next),
        .last     (at_last)
    );

    assign next_sel = SEL_W'(elem_idx(int'(row_next), int'(col_next), N));

    always_comb begin
        state_next    = state_reg;
        out_data_next = out_data_reg;
        overrun_next  = overrun_reg;

        case (state_reg)
            ST_IDLE: if (capture) state_next = ST_SEND;
            ST_SEND: if (final_xfer && !capture) state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase

        // Element (0,0) comes straight from the bus since the snapshot is
        // being written on the same edge.
        if (capture) begin
            out_data_next = res_flat[ACC_W-1:0];
        end else if (xfer && !at_last) begin
            out_data_next = snap_reg[next_sel];
        end

        if (drop) begin
            overrun_next = 1'b1;
        end else if (ovr_clr) begin
            overrun_next = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= ST_IDLE;
            out_data_reg <= '0;
            overrun_reg  <= 1'b0;
            for (int i = 0; i < NN; i++) begin
                snap_reg[i] <= '0;
            end
        end else begin
            state_reg    <= state_next;
            out_data_reg <= out_data_next;
            overrun_reg  <= overrun_next;
            if (capture) begin
                for (int i = 0; i < NN; i++) begin
                    snap_reg[i] <= res_flat[i*ACC_W +: ACC_W];
                end
            end
        end
    end

    assign out_valid = (state_reg == ST_SEND);
    assign busy      = (state_reg == ST_SEND);
    assign out_data  = out_data_reg;
    assign out_row   = row;
    assign out_col   = col;
    assign out_last  = at_last && out_valid;
    assign overrun   = overrun_reg;

endmodule

// File: tb/tb_result_unloader.sv
// Scoreboard bench for result_unloader: expected elements queued at load time,
// compared as each transfer happens.
module tb_result_unloader;
    import mm_pkg::*;

    localparam int NN = N * N;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 res_load;
    logic [NN*ACC_W-1:0]  res_flat;
    logic [ACC_W-1:0]     out_data;
    logic [IDX_W-1:0]     out_row;
    logic [IDX_W-1:0]     out_col;
    logic                 out_valid;
    logic                 out_ready;
    logic                 out_last;
    logic                 busy;
    logic                 overrun;
    logic                 ovr_clr;

    result_unloader dut (
        .clk       (clk),
        .rst       (rst),
        .res_load  (res_load),
        .res_flat  (res_flat),
        .out_data  (out_data),
        .out_row   (out_row),
        .out_col   (out_col),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last),
        .busy      (busy),
        .overrun   (overrun),
        .ovr_clr   (ovr_clr)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [ACC_W-1:0] data;
        logic [IDX_W-1:0] row;
        logic [IDX_W-1:0] col;
        logic             last;
    } exp_t;

    exp_t             sb[$];
    exp_t             e;
    exp_t             prev;
    bit               stalled = 1'b0;
    logic [ACC_W-1:0] mat [NN];
    int               errors = 0;
    int               checks = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // Transfers are sampled on the falling edge; inputs only move just after rising edges.
    always @(negedge clk) begin
        if (rst) begin
            stalled = 1'b0;
        end else begin
            if (stalled) begin
                check("stall_data", 32'(out_data), 32'(prev.data));
                check("stall_row",  32'(out_row),  32'(prev.row));
                check("stall_col",  32'(out_col),  32'(prev.col));
                check("stall_valid", 32'(out_valid), 32'd1);
            end
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    check("unexpected_xfer", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    check("xfer_data", 32'(out_data), 32'(e.data));
                    check("xfer_row",  32'(out_row),  32'(e.row));
                    check("xfer_col",  32'(out_col),  32'(e.col));
                    check("xfer_last", 32'(out_last), 32'(e.last));
                    $display("xfer row=%0d col=%0d data=%0d last=%0d", out_row, out_col, out_data, out_last);
                end
            end
            stalled = out_valid && !out_ready;
            prev    = '{data: out_data, row: out_row, col: out_col, last: out_last};
        end
    end

    task automatic set_flat();
        for (int i = 0; i < NN; i++) res_flat[i*ACC_W +: ACC_W] = mat[i];
    endtask

    task automatic push_mat();
        for (int i = 0; i < NN; i++) begin
            sb.push_back('{data: mat[i], row: IDX_W'(i / N), col: IDX_W'(i % N), last: (i == NN - 1)});
        end
    endtask

    task automatic do_load(input bit push);
        set_flat();
        if (push) push_mat();
        res_load = 1'b1;
        @(posedge clk); #1;
        res_load = 1'b0;
    endtask

    task automatic wait_drain(input string tag);
        for (int k = 0; k < 300 && sb.size() != 0; k++) begin
            @(posedge clk); #1;
        end
        check({tag, "_drained"}, 32'(sb.size()), 32'd0);
    endtask

    task automatic wait_rc(input int r, input int c, input string tag);
        bit found = 1'b0;
        for (int k = 0; k < 50 && !found; k++) begin
            if (out_valid && out_row == IDX_W'(r) && out_col == IDX_W'(c)) found = 1'b1;
            else begin @(posedge clk); #1; end
        end
        check({tag, "_reached"}, 32'(found), 32'd1);
    endtask

    initial begin
        rst = 1'b1; res_load = 1'b0; out_ready = 1'b0; ovr_clr = 1'b0; res_flat = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_busy",  32'(busy),      32'd0);
        check("rst_data",  32'(out_data),  32'd0);
        check("rst_ovr",   32'(overrun),   32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Basic stream: element(r,c) = 10*r + c.
        out_ready = 1'b1;
        for (int i = 0; i < NN; i++) mat[i] = ACC_W'(10 * (i / N) + (i % N));
        do_load(1'b1);
        check("basic_valid_lat", 32'(out_valid), 32'd1);
        check("basic_busy_lat",  32'(busy),      32'd1);
        check("basic_first",     32'(out_data),  32'd0);
        wait_drain("basic");
        check("basic_valid_end", 32'(out_valid), 32'd0);
        check("basic_busy_end",  32'(busy),      32'd0);
        check("basic_last_end",  32'(out_last),  32'd0);

        // Backpressure with wide values (1023 down).
        out_ready = 1'b0;
        for (int i = 0; i < NN; i++) mat[i] = ACC_W'(1023 - i);
        do_load(1'b1);
        for (int k = 0; k < 300 && sb.size() != 0; k++) begin
            out_ready = (k % 3 == 0) || ($urandom_range(0, 3) == 0);
            @(posedge clk); #1;
        end
        check("bp_drained", 32'(sb.size()), 32'd0);
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_idle", 32'(out_valid), 32'd0);

        // Dropped load while showing (1,1).
        for (int i = 0; i < NN; i++) mat[i] = ACC_W'(100 + i);
        do_load(1'b1);
        wait_rc(1, 1, "drop");
        for (int i = 0; i < NN; i++) mat[i] = ACC_W'(500 + i);
        do_load(1'b0);
        check("drop_ovr_set", 32'(overrun), 32'd1);
        wait_drain("drop");
        check("drop_ovr_sticky", 32'(overrun), 32'd1);
        ovr_clr = 1'b1;
        @(posedge clk); #1;
        ovr_clr = 1'b0;
        check("drop_ovr_clr", 32'(overrun), 32'd0);

        // Drop coincident with ovr_clr: the drop wins.
        for (int i = 0; i < NN; i++) mat[i] = ACC_W'(200 + 7 * i);
        do_load(1'b1);
        ovr_clr = 1'b1;
        do_load(1'b0);
        ovr_clr = 1'b0;
        check("prec_ovr", 32'(overrun), 32'd1);
        wait_drain("prec");
        ovr_clr = 1'b1;
        @(posedge clk); #1;
        ovr_clr = 1'b0;
        check("prec_ovr_clr", 32'(overrun), 32'd0);

        // Back-to-back: new load on the (2,2) transfer.
        for (int i = 0; i < NN; i++) mat[i] = ACC_W'(300 + i);
        do_load(1'b1);
        wait_rc(N - 1, N - 1, "b2b");
        for (int i = 0; i < NN; i++) mat[i] = ACC_W'(600 + 3 * i);
        do_load(1'b1);
        check("b2b_valid", 32'(out_valid), 32'd1);
        check("b2b_row",   32'(out_row),   32'd0);
        check("b2b_col",   32'(out_col),   32'd0);
        check("b2b_data",  32'(out_data),  32'd600);
        check("b2b_ovr",   32'(overrun),   32'd0);
        wait_drain("b2b");

        // Async reset mid-stream at (1,0).
        for (int i = 0; i < NN; i++) mat[i] = ACC_W'(40 + i);
        do_load(1'b1);
        wait_rc(1, 0, "arst");
        #2 rst = 1'b1;
        #1;
        check("arst_valid", 32'(out_valid), 32'd0);
        check("arst_data",  32'(out_data),  32'd0);
        check("arst_row",   32'(out_row),   32'd0);
        check("arst_busy",  32'(busy),      32'd0);
        check("arst_last",  32'(out_last),  32'd0);
        sb.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            check("arst_quiet", 32'(out_valid), 32'd0);
        end

        // Snapshot isolation: bus scrambled every cycle after capture.
        out_ready = 1'b0;
        for (int i = 0; i < NN; i++) mat[i] = ACC_W'($urandom_range(0, 1023));
        do_load(1'b1);
        for (int k = 0; k < 300 && sb.size() != 0; k++) begin
            for (int i = 0; i < NN; i++) res_flat[i*ACC_W +: ACC_W] = ACC_W'($urandom);
            out_ready = $urandom_range(0, 1) == 1;
            @(posedge clk); #1;
        end
        check("iso_drained", 32'(sb.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
